valve_driver: RTL
=================

Name: valve_driver

Overview:
- Downstream actuator stage of the irrigation controller. It consumes the zone valve commands R1/R2 and the error code E, and drives the four physical valve outputs.
- Enforces three protections:
  - staggered opening, so at most one valve opens per STAGGER cycles (limits pressure inrush);
  - minimum on-time per valve;
  - per-valve maximum run-time watchdog.
- Latches a global fault that closes all valves immediately.

Parameters:
- STAGGER, 4: minimum cycles between two successive valve openings (>=1).
- MIN_ON, 8: minimum cycles a valve stays open once opened (>=1).
- MAX_ON, 1000: cycles of continuous opening after which a valve is forced closed (must be > MIN_ON).
- CNT_W, 16: width of on-time and stagger counters (2**CNT_W > MAX_ON).

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: synchronous, active-high reset.
- R1, input, 4: zone 1 commands. [3:2] = channel 3, [1:0] = channel 2. 2'b01 = water, any other value = stop.
- R2, input, 4: zone 2 commands. [3:2] = channel 1, [1:0] = channel 0.
- E, input, 2: controller status. 2'b01 = no error; 2'b00 = error; 2'b10 and 2'b11 are illegal and treated as error.
- V, output, 4: valve drive, V[k] = channel k open.
- fault, output, 1: fault latched; all valves closed.
- timeout, output, 4: channel k was forced closed by the watchdog (sticky).
- busy, output, 1: high when in state RUN.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values: V=0, fault=0, timeout=0, busy=0, stagger counter=0, all on-counters=0, rr_ptr=0, state=IDLE. Reset dominates every other event, including mid-stagger and mid-fault.
- Request decode: req[k] = (field_k == 2'b01).
- States:
  - IDLE: V==0 and no req.
  - RUN: any V bit set or any req.
  - FAULT: entered on fault.
  - IDLE<->RUN transitions are evaluated on the registered next-cycle values.
- Fault entry: in any state, if E != 2'b01, then on the next cycle:
  - V=0, fault=1, state=FAULT;
  - on-counters and stagger counter cleared.
  - Fault has priority over open, close and timeout in the same cycle.
- Fault exit: when E==2'b01 and all four req==0 in the same cycle, the next cycle has fault=0 and state=IDLE. While in FAULT no valve opens.
- Opening:
  - Channel k is eligible when req[k] && !V[k] && !timeout[k] && stagger==0 && state!=FAULT.
  - At most one grant per cycle, chosen round-robin searching ascending k from rr_ptr (mod 4).
  - The granted channel has V[k]=1 next cycle, so latency is 1 cycle from the sampled request.
  - On a grant, stagger loads STAGGER-1 and rr_ptr becomes (k+1) mod 4.
  - stagger decrements by 1 per cycle while nonzero.
  - STAGGER=1 therefore allows one grant every cycle.
- On-counter: on_cnt[k] increments each cycle V[k]==1, saturating, and clears when V[k]==0.
- Closing on request drop: if V[k] && !req[k] && on_cnt[k] >= MIN_ON-1, then V[k]=0 next cycle. A valve is therefore open for exactly MIN_ON cycles if its request drops early. Any number of channels may close in the same cycle.
- Watchdog: if V[k] && on_cnt[k] == MAX_ON-1, then next cycle V[k]=0 and timeout[k]=1. A close and a watchdog trip in the same cycle produce the same V result; timeout is still set.
- timeout[k] clears on the cycle after req[k]==0 is sampled. The channel may then re-arm on a later request.
- Close and open events on different channels in the same cycle are independent. A channel closed this cycle is not eligible to open until the following cycle.

Decomposition:
- Package riego_pkg holds:
  - valve command constants VALVE_STOP=2'b00 and VALVE_AGUA=2'b01;
  - status constants ERR=2'b00 and NO_ERR=2'b01;
  - drv_state_t enum {IDLE, RUN, FAULT}.
- One sub-module, valve_channel, instantiated 4×. It holds on_cnt, the min-on close rule, the watchdog and the timeout flag, and takes grant and clear_all (fault) inputs.
- The top level holds the arbiter, the stagger counter and the FSM.

Test Plan:
- Reset, then E=01, R1=4'b0100 (channel 3) → V=4'b1000 exactly one cycle after the request is sampled; busy=1; fault=0.
- Reset, E=01, R1=R2=4'b0101 in one cycle, STAGGER=4 → V[0], V[1], V[2], V[3] rise at cycles +1, +5, +9, +13 respectively; reset asserted at cycle +7 → V=0 next cycle and channels 2/3 never open.
- MIN_ON=8: channel 0 requested for 2 cycles then dropped → V[0] high for exactly 8 cycles; with the request held for 12 cycles, V[0] falls 1 cycle after the drop.
- MAX_ON=20 (bench override), channel 1 held on → V[1] falls after 20 cycles, timeout=4'b0010; V[1] stays 0 while requested; drop for 1 cycle then re-request → timeout clears and V[1] reopens.
- Three valves open, E=2'b00 for 1 cycle → V=0000 and fault=1 next cycle; E=01 with requests still on → fault holds; all requests stop → fault=0, state IDLE next cycle.
- E=2'b11 during a cycle in which a grant and a watchdog trip coincide → fault wins: V=0000, fault=1, no new grant.

Source files
------------

// File: rtl/riego_pkg.sv
// Shared constants and types for the irrigation controller.
// Command/status encodings plus the valve driver state type.
package riego_pkg;

    localparam logic [1:0] VALVE_STOP = 2'b00;
    localparam logic [1:0] VALVE_AGUA = 2'b01;

    localparam logic [1:0] ERR    = 2'b00;
    localparam logic [1:0] NO_ERR = 2'b01;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } drv_state_t;

    function automatic logic is_water(input logic [1:0] cmd);
        return cmd == VALVE_AGUA;
    endfunction

endpackage

// File: rtl/valve_channel.sv
// One physical valve: open on grant, min-on close rule,
// run-time watchdog with sticky timeout flag.
module valve_channel
    import riego_pkg::*;
#(
    parameter int MIN_ON = 8,
    parameter int MAX_ON = 1000,
    parameter int CNT_W  = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic grant,
    input  logic clear_all,
    output logic v,
    output logic v_nxt,
    output logic timeout
);

    logic [CNT_W-1:0] on_cnt;
    logic             close;
    logic             trip;

    // Close/trip decisions and the valve's next value
    always_comb begin
        close = v && !req && (on_cnt >= CNT_W'(MIN_ON - 1));
        trip  = v && (on_cnt == CNT_W'(MAX_ON - 1));
        v_nxt = v;
        if (clear_all)
            v_nxt = 1'b0;
        else if (close || trip)
            v_nxt = 1'b0;
        else if (grant)
            v_nxt = 1'b1;
    end

    // Valve, saturating on-time counter and sticky watchdog flag
    always_ff @(posedge clk) begin
        if (reset) begin
            v       <= 1'b0;
            on_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            v <= v_nxt;
            if (clear_all || !v)
                on_cnt <= '0;
            else if (on_cnt != {CNT_W{1'b1}})
                on_cnt <= on_cnt + CNT_W'(1);
            if (!clear_all && trip)
                timeout <= 1'b1;
            else if (!req)
                timeout <= 1'b0;
        end
    end

endmodule

// File: rtl/valve_driver.sv
// Valve actuator stage: round-robin staggered opening,
// per-channel protection and a latched global fault.
module valve_driver
    import riego_pkg::*;
#(
    parameter int STAGGER = 4,
    parameter int MIN_ON  = 8,
    parameter int MAX_ON  = 1000,
    parameter int CNT_W   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] R1,
    input  logic [3:0] R2,
    input  logic [1:0] E,
    output logic [3:0] V,
    output logic       fault,
    output logic [3:0] timeout,
    output logic       busy
);

    drv_state_t       state;
    drv_state_t       state_nxt;
    logic [CNT_W-1:0] stagger;
    logic [1:0]       rr_ptr;
    logic [3:0]       req;
    logic [3:0]       elig;
    logic [3:0]       grant;
    logic [3:0]       v_nxt;
    logic [1:0]       gidx;
    logic             found;
    logic             err;
    logic             open_ok;

    assign req[3] = is_water(R1[3:2]);
    assign req[2] = is_water(R1[1:0]);
    assign req[1] = is_water(R2[3:2]);
    assign req[0] = is_water(R2[1:0]);

    assign err     = (E != NO_ERR);
    assign open_ok = (stagger == '0) && (state != FAULT) && !err;
    assign elig    = req & ~V & ~timeout & {4{open_ok}};

    assign fault = (state == FAULT);
    assign busy  = (state == RUN);

    // Round-robin pick of at most one eligible channel from rr_ptr
    always_comb begin
        logic [1:0] idx;
        grant = '0;
        gidx  = rr_ptr;
        found = 1'b0;
        idx   = rr_ptr;
        for (int i = 0; i < 4; i++) begin
            idx = rr_ptr + 2'(i);
            if (!found && elig[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
        if (found)
            grant[gidx] = 1'b1;
    end

    for (genvar k = 0; k < 4; k++) begin : g_ch
        valve_channel #(
            .MIN_ON (MIN_ON),
            .MAX_ON (MAX_ON),
            .CNT_W  (CNT_W)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .req       (req[k]),
            .grant     (grant[k]),
            .clear_all (err),
            .v         (V[k]),
            .v_nxt     (v_nxt[k]),
            .timeout   (timeout[k])
        );
    end

    // Next state: error forces FAULT, FAULT waits for all stop
    always_comb begin
        state_nxt = state;
        unique case (1'b1)
            err:
                state_nxt = FAULT;
            (!err && state == FAULT):
                state_nxt = (|req) ? FAULT : IDLE;
            (!err && state != FAULT):
                state_nxt = (|v_nxt || |req) ? RUN : IDLE;
        endcase
    end

    // State, stagger spacing counter and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            stagger <= '0;
            rr_ptr  <= 2'd0;
        end else begin
            state <= state_nxt;
            if (err)
                stagger <= '0;
            else if (found)
                stagger <= CNT_W'(STAGGER - 1);
            else if (stagger != '0)
                stagger <= stagger - CNT_W'(1);
            if (found)
                rr_ptr <= gidx + 2'd1;
        end
    end

endmodule
